// File: rtl/rv32i_lsu_pkg.sv
// Shared types and decode helpers for the RV32I load/store unit.
package rv32i_lsu_pkg;

    typedef enum logic [4:0] {
        LUI, AUIPC, JAL, JALR, BEQ, BNE, ADDI, ADD, SUB, XORI,
        LB, LH, LW, LBU, LHU, SB, SH, SW, FENCE, ECALL
    } RV32I_INSTRUCTION_MNEMONIC_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RVALID, DONE} lsu_state_t;

    typedef logic [3:0] mem_be_t;

    function automatic logic is_load(input RV32I_INSTRUCTION_MNEMONIC_t mn);
        return (mn == LB) || (mn == LH) || (mn == LW) || (mn == LBU) || (mn == LHU);
    endfunction

    function automatic logic is_store(input RV32I_INSTRUCTION_MNEMONIC_t mn);
        return (mn == SB) || (mn == SH) || (mn == SW);
    endfunction

    function automatic logic is_mem(input RV32I_INSTRUCTION_MNEMONIC_t mn);
        return is_load(mn) || is_store(mn);
    endfunction

    // Byte accesses can never trap; halves need bit 0 clear, words need both low bits clear.
    function automatic logic is_misaligned(input RV32I_INSTRUCTION_MNEMONIC_t mn,
                                           input logic [1:0] addr_lo);
        case (mn)
            LH, LHU, SH: return addr_lo[0];
            LW, SW:      return |addr_lo;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_load_aligner.sv
// Extracts and sign/zero-extends the addressed byte/half from a load word; pure combinational.
// No state, no handshake: result follows rdata, addr_lo and mnemonic in the same cycle.
module rv32i_load_aligner
    import rv32i_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              rdata,
    input  logic [1:0]                   addr_lo,
    input  RV32I_INSTRUCTION_MNEMONIC_t  mnemonic,
    output logic [XLEN-1:0]              result
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = rdata[{addr_lo, 3'b000} +: 8];
        half_val = rdata[{addr_lo[1], 4'b0000} +: 16];
        case (mnemonic)
            LB:      result = {{(XLEN-8){byte_val[7]}}, byte_val};
            LBU:     result = {{(XLEN-8){1'b0}}, byte_val};
            LH:      result = {{(XLEN-16){half_val[15]}}, half_val};
            LHU:     result = {{(XLEN-16){1'b0}}, half_val};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: req/gnt/rvalid data-memory FSM with lane steering, alignment trap, timeout.
// Latency store 3, load 4, misaligned 2 cycles; core is stalled until lsu_done, mem_req held until mem_gnt.
module rv32i_lsu
    import rv32i_lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         lsu_valid,
    input  RV32I_INSTRUCTION_MNEMONIC_t  mnemonic,
    input  logic [XLEN-1:0]              lsu_addr,
    input  logic [XLEN-1:0]              lsu_wdata,
    output logic                         lsu_stall,
    output logic                         lsu_done,
    output logic [XLEN-1:0]              lsu_rdata,
    output logic                         lsu_misaligned,
    output logic                         lsu_bus_err,
    output logic                         mem_req,
    output logic                         mem_we,
    output mem_be_t                      mem_be,
    output logic [XLEN-1:0]              mem_addr,
    output logic [XLEN-1:0]              mem_wdata,
    input  logic                         mem_gnt,
    input  logic                         mem_rvalid,
    input  logic [XLEN-1:0]              mem_rdata
);

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

    lsu_state_t                   state;
    logic [15:0]                  cnt;
    logic [15:0]                  cnt_nxt;
    logic                         timeout_hit;
    RV32I_INSTRUCTION_MNEMONIC_t  op_q;
    logic [1:0]                   lo_q;
    mem_be_t                      st_be;
    logic [XLEN-1:0]              st_wdata;
    logic [XLEN-1:0]              ld_result;

    assign lsu_stall   = lsu_valid & is_mem(mnemonic) & ~lsu_done;
    assign cnt_nxt     = cnt + 16'd1;
    // Expiry is judged on the count this cycle would reach, so TIMEOUT cycles are spent waiting.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_nxt == TO_LIMIT);

    always_comb begin
        st_be    = 4'hF;
        st_wdata = lsu_wdata;
        case (mnemonic)
            SB: begin
                st_be    = mem_be_t'(4'b0001 << lsu_addr[1:0]);
                st_wdata = {4{lsu_wdata[7:0]}};
            end
            SH: begin
                st_be    = lsu_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{lsu_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    rv32i_load_aligner #(.XLEN(XLEN)) u_aligner (
        .rdata    (mem_rdata),
        .addr_lo  (lo_q),
        .mnemonic (op_q),
        .result   (ld_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            op_q           <= ADD;
            lo_q           <= '0;
            lsu_done       <= 1'b0;
            lsu_rdata      <= '0;
            lsu_misaligned <= 1'b0;
            lsu_bus_err    <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_be         <= '0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
        end else begin
            lsu_done       <= 1'b0;
            lsu_misaligned <= 1'b0;
            lsu_bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (lsu_valid && is_mem(mnemonic)) begin
                        op_q <= mnemonic;
                        lo_q <= lsu_addr[1:0];
                        cnt  <= '0;
                        if (is_misaligned(mnemonic, lsu_addr[1:0])) begin
                            state          <= DONE;
                            lsu_done       <= 1'b1;
                            lsu_misaligned <= 1'b1;
                            lsu_rdata      <= '0;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store(mnemonic);
                            mem_be    <= is_store(mnemonic) ? st_be : 4'hF;
                            mem_addr  <= {lsu_addr[XLEN-1:2], 2'b00};
                            mem_wdata <= is_store(mnemonic) ? st_wdata : '0;
                        end
                    end
                end
                REQ: begin
                    // A grant in the expiry cycle still completes the access.
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        cnt     <= '0;
                        if (is_store(op_q)) begin
                            state     <= DONE;
                            lsu_done  <= 1'b1;
                            lsu_rdata <= '0;
                        end else begin
                            state <= WAIT_RVALID;
                        end
                    end else if (timeout_hit) begin
                        mem_req     <= 1'b0;
                        cnt         <= '0;
                        state       <= DONE;
                        lsu_done    <= 1'b1;
                        lsu_bus_err <= 1'b1;
                        lsu_rdata   <= '0;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                WAIT_RVALID: begin
                    if (mem_rvalid) begin
                        cnt       <= '0;
                        state     <= DONE;
                        lsu_done  <= 1'b1;
                        lsu_rdata <= ld_result;
                    end else if (timeout_hit) begin
                        cnt         <= '0;
                        state       <= DONE;
                        lsu_done    <= 1'b1;
                        lsu_bus_err <= 1'b1;
                        lsu_rdata   <= '0;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                DONE: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
